// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel: two register stages, one symbol per clock.
// Narrow colour components are widened by MSB-first bit replication before encoding.
module tmds_channel_encoder #(
  parameter int C_depth = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [C_depth-1:0] in_data,
  input  logic [1:0]         in_c,
  input  logic               in_blank,
  output logic [9:0]         out_tmds
);

  function automatic logic [7:0] expand_data(input logic [C_depth-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = v[C_depth-1-(i % C_depth)];
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // XNOR chain when the byte is ones-heavy (or a 4/4 split starting with 0); q_m[8] records XOR use
  function automatic logic [8:0] min_transitions(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q[i] = ~(q[i-1] ^ d[i]);
      end else begin
        q[i] = q[i-1] ^ d[i];
      end
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1q_d, n1q_q;
  logic              blank_q;
  logic [1:0]        c_q;
  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d, cnt_q;
  logic signed [4:0] n1_s, n0_s;

  // Stage 1 combinational: transition-minimised word and its ones count
  always_comb begin
    qm_d  = min_transitions(expand_data(in_data));
    n1q_d = popcount8(qm_d[7:0]);
  end

  // Stage 1 registers; reset state is "blank, c=00"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qm_q    <= 9'd0;
      n1q_q   <= 4'd0;
      blank_q <= 1'b1;
      c_q     <= 2'b00;
    end else begin
      qm_q    <= qm_d;
      n1q_q   <= n1q_d;
      blank_q <= in_blank;
      c_q     <= in_c;
    end
  end

  // Stage 2 combinational: control token or DC-balanced data symbol plus disparity update
  always_comb begin
    n1_s   = signed'({1'b0, n1q_q});
    n0_s   = 5'sd8 - n1_s;
    tmds_d = 10'h354;
    cnt_d  = cnt_q;
    if (blank_q) begin
      cnt_d = 5'sd0;
      case (c_q)
        2'b00:   tmds_d = 10'h354;
        2'b01:   tmds_d = 10'h0AB;
        2'b10:   tmds_d = 10'h154;
        2'b11:   tmds_d = 10'h2AB;
        default: tmds_d = 10'h354;
      endcase
    end else if ((cnt_q == 5'sd0) || (n1_s == n0_s)) begin
      tmds_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
      if (qm_q[8]) begin
        cnt_d = cnt_q + n1_s - n0_s;
      end else begin
        cnt_d = cnt_q + n0_s - n1_s;
      end
    end else if (((cnt_q > 5'sd0) && (n1_s > n0_s)) || ((cnt_q < 5'sd0) && (n0_s > n1_s))) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) + n0_s - n1_s;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + n1_s - n0_s;
    end
  end

  // Stage 2 registers: output symbol and running disparity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmds_q <= 10'h354;
      cnt_q  <= 5'sd0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: an 8-bit and a 3-bit instance share control inputs;
// the driver queues hand-computed symbols, a monitor pops them two clocks later.
module tb_tmds_channel_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic [2:0] d3 = 3'b000;
  logic [1:0] c = 2'b00;
  logic       blank = 1'b1;
  logic [9:0] out8, out3;

  always #20 clk = ~clk;

  tmds_channel_encoder #(.C_depth(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_data(d8), .in_c(c), .in_blank(blank), .out_tmds(out8)
  );
  tmds_channel_encoder #(.C_depth(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(d3), .in_c(c), .in_blank(blank), .out_tmds(out3)
  );

  typedef struct {
    logic [9:0] exp8;
    bit         chk8;
    bit         dec8;
    logic [7:0] dv8;
    logic [9:0] exp3;
    bit         chk3;
    bit         dec3;
    logic [7:0] dv3;
    string      name;
  } exp_t;

  exp_t     sb_q[$];
  int       checks = 0;
  int       errors = 0;
  bit       drv_valid = 1'b0;
  bit [1:0] vld_pipe = 2'b00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_pipe <= 2'b00;
    else          vld_pipe <= {vld_pipe[0], drv_valid};
  end

  function automatic logic [9:0] tok(input logic [1:0] cv);
    case (cv)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Standard TMDS data decoder (receiver side), independent of the encoder's decision rules.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, r;
    w    = s[9] ? ~s[7:0] : s[7:0];
    r    = 8'h00;
    r[0] = w[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_pipe[1]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got a symbol expected none queued");
        end else begin
          e = sb_q.pop_front();
          if (e.chk8) chk({e.name, "_d8"}, out8, e.exp8);
          if (e.dec8) chk({e.name, "_dec8"}, {2'b00, decode(out8)}, {2'b00, e.dv8});
          if (e.chk3) chk({e.name, "_d3"}, out3, e.exp3);
          if (e.dec3) chk({e.name, "_dec3"}, {2'b00, decode(out3)}, {2'b00, e.dv3});
        end
      end
    end
  endtask

  // Drive one pixel (also releases reset) and queue its expected symbols.
  task automatic px(input bit b, input logic [1:0] cv, input logic [7:0] v8, input logic [2:0] v3,
                    input logic [9:0] e8, input bit c3, input logic [9:0] e3, input string nm);
    exp_t e;
    @(negedge clk);
    reset_n = 1'b1;
    blank = b; c = cv; d8 = v8; d3 = v3; drv_valid = 1'b1;
    e.exp8 = e8; e.chk8 = 1'b1; e.dec8 = !b; e.dv8 = v8;
    e.exp3 = e3; e.chk3 = c3;   e.dec3 = 1'b0; e.dv3 = 8'h00;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   wait_cnt;
    fork
      monitor();
    join_none

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      blank = 1'($urandom); c = 2'($urandom); d8 = 8'($urandom); d3 = 3'($urandom);
      #1;
      chk("rst_hold8", out8, 10'h354);
      chk("rst_hold3", out3, 10'h354);
    end

    // Release with c=01: first edge still shows the reset token, second edge 0AB
    px(1'b1, 2'b01, 8'h5A, 3'b010, 10'h0AB, 1'b1, 10'h0AB, "rel_c01");
    @(posedge clk); #1;
    chk("rel_edge1", out8, 10'h354);
    px(1'b1, 2'b10, 8'hFF, 3'b111, 10'h154, 1'b1, 10'h154, "tok_c10");
    px(1'b1, 2'b11, 8'h00, 3'b000, 10'h2AB, 1'b1, 10'h2AB, "tok_c11");
    px(1'b1, 2'b00, 8'h33, 3'b101, 10'h354, 1'b1, 10'h354, "tok_c00");

    // Ones-heavy data (XNOR path); in_c ignored while active
    px(1'b0, 2'b11, 8'hFF, 3'b111, 10'h200, 1'b1, 10'h200, "ff_1");
    px(1'b0, 2'b10, 8'hFF, 3'b111, 10'h0FF, 1'b1, 10'h0FF, "ff_2");
    px(1'b0, 2'b01, 8'hFF, 3'b111, 10'h0FF, 1'b1, 10'h0FF, "ff_3");
    px(1'b1, 2'b00, 8'hFF, 3'b111, 10'h354, 1'b1, 10'h354, "blank_a");

    // Zeros (XOR path): cnt -8, +2, -6; balanced q_m with cnt != 0; then -6 -> +4
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h100, 1'b1, 10'h100, "z_1");
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h3FF, 1'b1, 10'h3FF, "z_2");
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h100, 1'b1, 10'h100, "z_3");
    px(1'b0, 2'b00, 8'h10, 3'b000, 10'h1F0, 1'b0, 10'h000, "bal_10");
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h3FF, 1'b0, 10'h000, "z_4");

    // Replication: 3'b101 expands to B6
    px(1'b1, 2'b11, 8'h00, 3'b000, 10'h2AB, 1'b1, 10'h2AB, "blank_b");
    px(1'b0, 2'b00, 8'hB6, 3'b101, 10'h2C7, 1'b1, 10'h2C7, "b6");

    // Blank toggling every cycle: each active pixel restarts from cnt=0
    px(1'b1, 2'b00, 8'h00, 3'b000, 10'h354, 1'b1, 10'h354, "tog_b1");
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h100, 1'b1, 10'h100, "tog_a1");
    px(1'b1, 2'b01, 8'h00, 3'b000, 10'h0AB, 1'b1, 10'h0AB, "tog_b2");
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h100, 1'b1, 10'h100, "tog_a2");

    // Mid-line reset: leave cnt at -8, reset, first active pixel must see cnt=0
    px(1'b1, 2'b00, 8'h00, 3'b000, 10'h354, 1'b1, 10'h354, "mr_blank");
    px(1'b0, 2'b00, 8'hFF, 3'b111, 10'h200, 1'b1, 10'h200, "mr_ff");
    @(negedge clk);
    drv_valid = 1'b0; d8 = 8'h00; d3 = 3'b000;
    @(negedge clk);
    #5 reset_n = 1'b0;
    #1;
    chk("mr_async8", out8, 10'h354);
    chk("mr_async3", out3, 10'h354);
    px(1'b0, 2'b00, 8'h00, 3'b000, 10'h100, 1'b1, 10'h100, "mr_first");

    // Random soak: tokens exact, data symbols must decode back to the input
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      blank = ($urandom_range(0, 5) == 0);
      c = 2'($urandom); d8 = 8'($urandom); d3 = 3'($urandom);
      drv_valid = 1'b1;
      e.name = "soak";
      e.chk8 = blank; e.exp8 = tok(c); e.dec8 = !blank; e.dv8 = d8;
      e.chk3 = blank; e.exp3 = tok(c); e.dec3 = !blank; e.dv3 = {d3, d3, d3[2:1]};
      sb_q.push_back(e);
    end

    @(negedge clk);
    drv_valid = 1'b0; blank = 1'b1; c = 2'b00;
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
